// File: rtl/cpe_pkg.sv
// Shared encodings for the CPE core: sequencer states and the legal opcode set.
// The opcode decoder uses the same opcode constants.
// is_legal_opcode() is the single place that defines which opcodes the core accepts.
package cpe_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic is_legal_opcode(input logic [6:0] opc);
        case (opc)
            OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_BRANCH, OPC_STORE,
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Wait-cycle counter for memory handshakes: clear, count enable, expiry flag.
// Latency: expired is combinational from the registered count (same cycle the limit is reached).
// Backpressure: none; the count holds at the limit. TIMEOUT_CYCLES=0 disables expiry.
module seq_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] cnt;

    // Count wait cycles; hold at the limit so a disabled or parked counter never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/[MEM]/WB with fault on illegal opcode or memory timeout.
// Latency: 4 cycles per ALU/branch/jump instruction, 5 for load/store, +1 per memory wait cycle.
// Backpressure: requests are held stable until mem_ack; optional instret counter via CPE_INSTRET_EN.
module cpu_sequencer
    import cpe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic       clk_w_i,
    input  logic       rst_w_i_h,
    input  logic [6:0] opcode_w_i,
    input  logic       reg_write_w_i_h,
    input  logic       mem_rd_w_i_h,
    input  logic       mem_wr_w_i_h,
    input  logic       jal_w_i_h,
    input  logic       cmp_branch_w_i_h,
    input  logic       branch_taken_w_i_h,
    input  logic       mem_ack_w_i_h,
    output logic       imem_req_w_o_h,
    output logic       dmem_rd_w_o_h,
    output logic       dmem_wr_w_o_h,
    output logic       ir_we_w_o_h,
    output logic       pc_we_w_o_h,
    output logic       pc_sel_w_o,
    output logic       reg_we_w_o_h,
    output logic       fault_w_o_h,
    output logic [2:0] state_w_o
`ifdef CPE_INSTRET_EN
    ,
    output logic [63:0] instret_w_o
`endif
);

    state_t state;
    logic   take;
    logic   reg_write_q;
    logic   mem_rd_q;
    logic   mem_wr_q;
    logic   in_wait;
    logic   to_expired;

    assign in_wait = (state == ST_FETCH) || (state == ST_MEM);

    // Counter is held clear outside the wait states, so it starts at 0 on every entry.
    seq_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_timeout (
        .clk    (clk_w_i),
        .rst    (rst_w_i_h),
        .clr    (!in_wait),
        .en     (in_wait && !mem_ack_w_i_h),
        .expired(to_expired)
    );

    // Sequencer FSM; decoder flags are captured only in EXEC, after the opcode passed the legality check.
    always_ff @(posedge clk_w_i) begin
        if (rst_w_i_h) begin
            state       <= ST_RST;
            take        <= 1'b0;
            reg_write_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            case (state)
                ST_RST:    state <= ST_FETCH;
                ST_FETCH: begin
                    if (mem_ack_w_i_h)   state <= ST_DECODE;
                    else if (to_expired) state <= ST_FAULT;
                end
                ST_DECODE: state <= is_legal_opcode(opcode_w_i) ? ST_EXEC : ST_FAULT;
                ST_EXEC: begin
                    take        <= jal_w_i_h | (cmp_branch_w_i_h & branch_taken_w_i_h);
                    reg_write_q <= reg_write_w_i_h;
                    mem_rd_q    <= mem_rd_w_i_h;
                    mem_wr_q    <= mem_wr_w_i_h;
                    state       <= (mem_rd_w_i_h || mem_wr_w_i_h) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (mem_ack_w_i_h)   state <= ST_WB;
                    else if (to_expired) state <= ST_FAULT;
                end
                ST_WB:     state <= ST_FETCH;
                ST_FAULT:  state <= ST_FAULT;
                default:   state <= ST_FAULT;
            endcase
        end
    end

    // Moore outputs decoded from the state register; ir_we alone follows mem_ack within FETCH.
    assign imem_req_w_o_h = (state == ST_FETCH);
    assign ir_we_w_o_h    = (state == ST_FETCH) && mem_ack_w_i_h;
    assign dmem_rd_w_o_h  = (state == ST_MEM) && mem_rd_q;
    assign dmem_wr_w_o_h  = (state == ST_MEM) && mem_wr_q;
    assign pc_we_w_o_h    = (state == ST_WB);
    assign pc_sel_w_o     = (state == ST_WB) && take;
    assign reg_we_w_o_h   = (state == ST_WB) && reg_write_q;
    assign fault_w_o_h    = (state == ST_FAULT);
    assign state_w_o      = state;

`ifdef CPE_INSTRET_EN
    logic [63:0] instret;

    // Retired-instruction count: one per WB cycle, wrapping naturally at 2^64.
    always_ff @(posedge clk_w_i) begin
        if (rst_w_i_h) begin
            instret <= 64'd0;
        end else if (state == ST_WB) begin
            instret <= instret + 64'd1;
        end
    end

    assign instret_w_o = instret;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer (TIMEOUT_CYCLES=4): stimulus pushes per-cycle expected
// state/outputs, a monitor pops and compares on the falling edge.
// Output vector order: {imem_req, dmem_rd, dmem_wr, ir_we, pc_we, pc_sel, reg_we, fault}.
module tb_cpu_sequencer;

    localparam logic [2:0] S_RST = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd6;

    localparam logic [7:0] O_NONE  = 8'h00;
    localparam logic [7:0] O_IREQ  = 8'h80;
    localparam logic [7:0] O_FACK  = 8'h90;
    localparam logic [7:0] O_DRD   = 8'h40;
    localparam logic [7:0] O_DWR   = 8'h20;
    localparam logic [7:0] O_WB    = 8'h08;
    localparam logic [7:0] O_WB_R  = 8'h0A;
    localparam logic [7:0] O_WB_T  = 8'h0C;
    localparam logic [7:0] O_WB_TR = 8'h0E;
    localparam logic [7:0] O_FLT   = 8'h01;

    logic       clk = 1'b0;
    logic       rst, ack, reg_write, mem_rd, mem_wr, jal, cmp_branch, taken;
    logic [6:0] opc;
    logic       imem_req, dmem_rd, dmem_wr, ir_we, pc_we, pc_sel, reg_we, fault;
    logic [2:0] state;
`ifdef CPE_INSTRET_EN
    logic [63:0] instret;
`endif

    always #5 clk = ~clk;

    cpu_sequencer #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk_w_i           (clk),
        .rst_w_i_h         (rst),
        .opcode_w_i        (opc),
        .reg_write_w_i_h   (reg_write),
        .mem_rd_w_i_h      (mem_rd),
        .mem_wr_w_i_h      (mem_wr),
        .jal_w_i_h         (jal),
        .cmp_branch_w_i_h  (cmp_branch),
        .branch_taken_w_i_h(taken),
        .mem_ack_w_i_h     (ack),
        .imem_req_w_o_h    (imem_req),
        .dmem_rd_w_o_h     (dmem_rd),
        .dmem_wr_w_o_h     (dmem_wr),
        .ir_we_w_o_h       (ir_we),
        .pc_we_w_o_h       (pc_we),
        .pc_sel_w_o        (pc_sel),
        .reg_we_w_o_h      (reg_we),
        .fault_w_o_h       (fault),
        .state_w_o         (state)
`ifdef CPE_INSTRET_EN
        ,
        .instret_w_o       (instret)
`endif
    );

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [7:0] o;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Monitor: one comparison per cycle that has an expectation queued.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {imem_req, dmem_rd, dmem_wr, ir_we, pc_we, pc_sel, reg_we, fault};
                checks++;
                if ({state, act} !== {e.st, e.o}) begin
                    failures++;
                    $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                             e.tag, state, act, e.st, e.o);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue what the DUT should show during that cycle.
    task automatic cyc(input string tag, input logic r, input logic a,
                       input logic [2:0] st, input logic [7:0] o);
        exp_t e;
        @(posedge clk);
        #1;
        rst   = r;
        ack   = a;
        e.tag = tag;
        e.st  = st;
        e.o   = o;
        sb.push_back(e);
    endtask

    task automatic set_flags(input logic [6:0] op, input logic rw, input logic rd, input logic wr,
                             input logic j, input logic cb, input logic tk);
        opc = op; reg_write = rw; mem_rd = rd; mem_wr = wr; jal = j; cmp_branch = cb; taken = tk;
    endtask

    // FETCH with optional wait cycles, DECODE (stray ack must be ignored), EXEC.
    task automatic front(input string tag, input int waits);
        for (int i = 0; i < waits; i++) cyc({tag, "_fwait"}, 1'b0, 1'b0, S_FETCH, O_IREQ);
        cyc({tag, "_fetch"},  1'b0, 1'b1, S_FETCH,  O_FACK);
        cyc({tag, "_decode"}, 1'b0, 1'b1, S_DECODE, O_NONE);
        cyc({tag, "_exec"},   1'b0, 1'b0, S_EXEC,   O_NONE);
    endtask

    initial begin
        rst = 1'b1;
        ack = 1'b0;
        set_flags(7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        cyc("reset",     1'b1, 1'b0, S_RST, O_NONE);
        cyc("reset_rel", 1'b0, 1'b0, S_RST, O_NONE);

        // ADD, ack in first fetch cycle: 1,2,3,5
        front("add", 0);
        cyc("add_wb", 1'b0, 1'b0, S_WB, O_WB_R);

        // LW with data ack on the 4th MEM cycle: 8 cycles total
        set_flags(7'b0000011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        front("lw", 0);
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, 1'b0, S_MEM, O_DRD);
        cyc("lw_mem_ack", 1'b0, 1'b1, S_MEM, O_DRD);
        cyc("lw_wb",      1'b0, 1'b0, S_WB,  O_WB_R);

        // SW, same shape, no register write
        set_flags(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        front("sw", 0);
        for (int i = 0; i < 3; i++) cyc("sw_mem_wait", 1'b0, 1'b0, S_MEM, O_DWR);
        cyc("sw_mem_ack", 1'b0, 1'b1, S_MEM, O_DWR);
        cyc("sw_wb",      1'b0, 1'b0, S_WB,  O_WB);

        // BEQ taken / not taken, JAL with taken=0
        set_flags(7'b1100011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        front("beq_t", 0);
        cyc("beq_t_wb", 1'b0, 1'b0, S_WB, O_WB_T);
        set_flags(7'b1100011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        front("beq_n", 0);
        cyc("beq_n_wb", 1'b0, 1'b0, S_WB, O_WB);
        set_flags(7'b1101111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        front("jal", 0);
        cyc("jal_wb", 1'b0, 1'b0, S_WB, O_WB_TR);

        // Fetch ack on the cycle the counter reaches the limit: ack wins
        set_flags(7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        front("add_late", 4);
        cyc("add_late_wb", 1'b0, 1'b0, S_WB, O_WB_R);

        // Illegal opcode with undefined decoder flags
        set_flags(7'b1111111, 1'bx, 1'bx, 1'bx, 1'bx, 1'bx, 1'bx);
        cyc("ill_fetch",  1'b0, 1'b1, S_FETCH,  O_FACK);
        cyc("ill_decode", 1'b0, 1'b0, S_DECODE, O_NONE);
        for (int i = 0; i < 10; i++) cyc("ill_fault", 1'b0, logic'(i % 2), S_FAULT, O_FLT);
        cyc("ill_rst",    1'b1, 1'b0, S_FAULT, O_FLT);
        cyc("ill_rst_st", 1'b0, 1'b0, S_RST,   O_NONE);

        // Fetch timeout: FAULT follows the 5th request cycle
        set_flags(7'b0000011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc("fto_wait", 1'b0, 1'b0, S_FETCH, O_IREQ);
        cyc("fto_fault",  1'b0, 1'b0, S_FAULT, O_FLT);
        cyc("fto_rst",    1'b1, 1'b0, S_FAULT, O_FLT);
        cyc("fto_rst_st", 1'b0, 1'b0, S_RST,   O_NONE);

        // Memory timeout in MEM
        front("mto", 0);
        for (int i = 0; i < 5; i++) cyc("mto_wait", 1'b0, 1'b0, S_MEM, O_DRD);
        cyc("mto_fault",  1'b0, 1'b0, S_FAULT, O_FLT);
        cyc("mto_rst",    1'b1, 1'b0, S_FAULT, O_FLT);
        cyc("mto_rst_st", 1'b0, 1'b0, S_RST,   O_NONE);

        // Reset during a MEM wait with the request high
        front("mrst", 0);
        cyc("mrst_wait",  1'b0, 1'b0, S_MEM, O_DRD);
        cyc("mrst_rst",   1'b1, 1'b0, S_MEM, O_DRD);
        cyc("mrst_rst_st", 1'b0, 1'b0, S_RST, O_NONE);
`ifdef CPE_INSTRET_EN
        @(negedge clk);
        checks++;
        if (instret !== 64'd0) begin
            failures++;
            $display("FAIL instret_reset: got %0d, expected 0", instret);
        end
`endif

        // Three back-to-back instructions: ADD, LW, SW
        set_flags(7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        front("cnt_add", 0);
        cyc("cnt_add_wb", 1'b0, 1'b0, S_WB, O_WB_R);
        set_flags(7'b0000011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        front("cnt_lw", 0);
        cyc("cnt_lw_mem", 1'b0, 1'b1, S_MEM, O_DRD);
        cyc("cnt_lw_wb",  1'b0, 1'b0, S_WB,  O_WB_R);
        set_flags(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        front("cnt_sw", 0);
        cyc("cnt_sw_mem", 1'b0, 1'b1, S_MEM, O_DWR);
        cyc("cnt_sw_wb",  1'b0, 1'b0, S_WB,  O_WB);
        cyc("cnt_next",   1'b0, 1'b0, S_FETCH, O_IREQ);
`ifdef CPE_INSTRET_EN
        @(negedge clk);
        checks++;
        if (instret !== 64'd3) begin
            failures++;
            $display("FAIL instret_count: got %0d, expected 3", instret);
        end
`endif

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations never compared, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
